// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// fpu_pkg : shared FSM states and default widths for the mantissa normalizer
// Revision : 1.0
// ============================================================================
package fpu_pkg;

  localparam int M_W_DEF    = 24;
  localparam int E_W_DEF    = 8;
  localparam int C_W_DEF    = 5;
  localparam int HIDDEN_BIT = M_W_DEF - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

endpackage
`default_nettype wire

// File: rtl/fp_normalize_seq_if.sv
`default_nettype none
// ============================================================================
// fp_normalize_seq_if : operand/result handshake bundle of the normalizer
// Revision : 1.0
// ============================================================================
interface fp_normalize_seq_if
  import fpu_pkg::*;
#(
  parameter int M_W = M_W_DEF,
  parameter int E_W = E_W_DEF,
  parameter int C_W = C_W_DEF
);

  logic           in_valid;
  logic           in_ready;
  logic [M_W-1:0] M_in;
  logic [E_W-1:0] E_in;
  logic           out_valid;
  logic           out_ready;
  logic [M_W-1:0] M_out;
  logic [E_W-1:0] E_out;
  logic [C_W-1:0] count;
  logic           zero;
  logic           underflow;

  modport master (
    output in_valid, M_in, E_in, out_ready,
    input  in_ready, out_valid, M_out, E_out, count, zero, underflow
  );

  modport slave (
    input  in_valid, M_in, E_in, out_ready,
    output in_ready, out_valid, M_out, E_out, count, zero, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fp_normalize_seq.sv
`default_nettype none
// ============================================================================
// fp_normalize_seq : one-shift-per-cycle mantissa normalizer with exponent
//                    adjust, zero detect and denormal-boundary stop
// Revision : 1.0
// ============================================================================
module fp_normalize_seq
  import fpu_pkg::*;
#(
  parameter int M_W = HIDDEN_BIT + 1,
  parameter int E_W = E_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fp_normalize_seq_if.slave bus
);

  norm_state_e    state_q, state_d;
  logic [M_W-1:0] m_r_q, m_r_d;
  logic [E_W-1:0] e_r_q, e_r_d;
  logic [C_W-1:0] c_r_q, c_r_d;
  logic [M_W-1:0] m_out_q, m_out_d;
  logic [E_W-1:0] e_out_q, e_out_d;
  logic [C_W-1:0] count_q, count_d;
  logic           zero_q, zero_d;
  logic           underflow_q, underflow_d;
  logic           w_accept;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.M_out     = m_out_q;
  assign bus.E_out     = e_out_q;
  assign bus.count     = count_q;
  assign bus.zero      = zero_q;
  assign bus.underflow = underflow_q;

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    m_r_d       = m_r_q;
    e_r_d       = e_r_q;
    c_r_d       = c_r_q;
    m_out_d     = m_out_q;
    e_out_d     = e_out_q;
    count_d     = count_q;
    zero_d      = zero_q;
    underflow_d = underflow_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          m_r_d   = bus.M_in;
          e_r_d   = bus.E_in;
          c_r_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Stop conditions are checked in priority order: zero, normalized, denormal boundary.
        if (m_r_q == '0) begin
          m_out_d     = '0;
          e_out_d     = '0;
          count_d     = '0;
          zero_d      = 1'b1;
          underflow_d = 1'b0;
          state_d     = DONE;
        end else if (m_r_q[M_W-1]) begin
          m_out_d     = m_r_q;
          e_out_d     = e_r_q;
          count_d     = c_r_q;
          zero_d      = 1'b0;
          underflow_d = 1'b0;
          state_d     = DONE;
        end else if (e_r_q <= E_W'(1)) begin
          m_out_d     = m_r_q;
          e_out_d     = '0;
          count_d     = c_r_q;
          zero_d      = 1'b0;
          underflow_d = 1'b1;
          state_d     = DONE;
        end else begin
          m_r_d = m_r_q << 1;
          e_r_d = e_r_q - E_W'(1);
          c_r_d = c_r_q + C_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_r_q       <= '0;
      e_r_q       <= '0;
      c_r_q       <= '0;
      m_out_q     <= '0;
      e_out_q     <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_r_q       <= m_r_d;
      e_r_q       <= e_r_d;
      c_r_q       <= c_r_d;
      m_out_q     <= m_out_d;
      e_out_q     <= e_out_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire
